// File: rtl/conv_job_sequencer.sv
// Sequences one 8.8 job through an external conv core: reset core, load operand, start, wait, read float16 result.
// Optional build macro: CONV_SEQ_STATS_EN adds saturating job_count / timeout_count outputs.
module conv_job_sequencer #(
    parameter int unsigned TIMEOUT_CYCLES = 4096,
    parameter int unsigned IN_LO_ADDR     = 0,
    parameter int unsigned IN_HI_ADDR     = 1,
    parameter int unsigned OUT_LO_ADDR    = 2,
    parameter int unsigned OUT_HI_ADDR    = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        job_valid,
    output logic        job_ready,
    input  logic [15:0] job_data,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [15:0] res_data,
    output logic        res_timeout,
    output logic        core_reset,
    output logic        core_start,
    input  logic        core_done,
    output logic        mem_sel,
    output logic        mem_we,
    output logic [7:0]  mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata
`ifdef CONV_SEQ_STATS_EN
    ,
    output logic [15:0] job_count,
    output logic [7:0]  timeout_count
`endif
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [3:0] {
        IDLE, CRST, WR_LO, WR_HI, START, WAIT, RD_LO, RD_HI, RESP
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [15:0]      job_q, job_nxt;
    logic [15:0]      res_data_nxt;
    logic             res_timeout_nxt;
    logic             job_ready_nxt, res_valid_nxt, core_reset_nxt, core_start_nxt;
    logic             mem_sel_nxt, mem_we_nxt;
    logic [7:0]       mem_addr_nxt, mem_wdata_nxt;

    // State, datapath and registered outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            cnt         <= '0;
            job_q       <= '0;
            res_data    <= '0;
            res_timeout <= 1'b0;
            res_valid   <= 1'b0;
            job_ready   <= 1'b1;
            core_reset  <= 1'b1;
            core_start  <= 1'b0;
            mem_sel     <= 1'b1;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            job_q       <= job_nxt;
            res_data    <= res_data_nxt;
            res_timeout <= res_timeout_nxt;
            res_valid   <= res_valid_nxt;
            job_ready   <= job_ready_nxt;
            core_reset  <= core_reset_nxt;
            core_start  <= core_start_nxt;
            mem_sel     <= mem_sel_nxt;
            mem_we      <= mem_we_nxt;
            mem_addr    <= mem_addr_nxt;
            mem_wdata   <= mem_wdata_nxt;
        end
    end

    // Next state, datapath, and outputs decoded from the state being entered
    always_comb begin
        state_nxt       = state;
        cnt_nxt         = cnt;
        job_nxt         = job_q;
        res_data_nxt    = res_data;
        res_timeout_nxt = res_timeout;

        case (state)
            IDLE: begin
                if (job_valid && job_ready) begin
                    job_nxt   = job_data;
                    state_nxt = CRST;
                end
            end
            CRST:  state_nxt = WR_LO;
            WR_LO: state_nxt = WR_HI;
            WR_HI: state_nxt = START;
            START: begin
                cnt_nxt   = '0;
                state_nxt = WAIT;
            end
            WAIT: begin
                cnt_nxt = cnt + CNT_W'(1);
                // done wins over a coincident timeout
                if (core_done) begin
                    state_nxt = RD_LO;
                end else if (cnt == CNT_LAST) begin
                    res_data_nxt    = 16'hFFFF;
                    res_timeout_nxt = 1'b1;
                    state_nxt       = RESP;
                end
            end
            RD_LO: begin
                res_data_nxt[7:0] = mem_rdata;
                res_timeout_nxt   = 1'b0;
                state_nxt         = RD_HI;
            end
            RD_HI: begin
                res_data_nxt[15:8] = mem_rdata;
                state_nxt          = RESP;
            end
            RESP: begin
                if (res_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase

        job_ready_nxt  = (state_nxt == IDLE);
        core_reset_nxt = (state_nxt == CRST);
        core_start_nxt = (state_nxt == START);
        res_valid_nxt  = (state_nxt == RESP);
        mem_sel_nxt    = !((state_nxt == START) || (state_nxt == WAIT));
        mem_we_nxt     = (state_nxt == WR_LO) || (state_nxt == WR_HI);
        mem_addr_nxt   = '0;
        mem_wdata_nxt  = '0;

        case (state_nxt)
            WR_LO: begin
                mem_addr_nxt  = 8'(IN_LO_ADDR);
                mem_wdata_nxt = job_nxt[7:0];
            end
            WR_HI: begin
                mem_addr_nxt  = 8'(IN_HI_ADDR);
                mem_wdata_nxt = job_nxt[15:8];
            end
            RD_LO:   mem_addr_nxt = 8'(OUT_LO_ADDR);
            RD_HI:   mem_addr_nxt = 8'(OUT_HI_ADDR);
            default: ;
        endcase
    end

`ifdef CONV_SEQ_STATS_EN
    logic resp_fire;
    assign resp_fire = (state == RESP) && res_ready;

    // Saturating result counters, bumped on the result handshake
    always_ff @(posedge clk) begin
        if (!rst) begin
            job_count     <= '0;
            timeout_count <= '0;
        end else if (resp_fire) begin
            if (job_count != 16'hFFFF) job_count <= job_count + 16'd1;
            if (res_timeout && (timeout_count != 8'hFF)) timeout_count <= timeout_count + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_conv_job_sequencer.sv
// Scoreboard bench for conv_job_sequencer: directed jobs, behavioural core model, result monitor.
module tb_conv_job_sequencer;

    localparam int unsigned TMO   = 64;
    localparam int unsigned TMO_T = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        job_valid = 1'b0, job_ready;
    logic [15:0] job_data = 16'h0;
    logic        res_valid, res_ready = 1'b1, res_timeout;
    logic [15:0] res_data;
    logic        core_reset, core_start, core_done = 1'b0;
    logic        mem_sel, mem_we;
    logic [7:0]  mem_addr, mem_wdata, mem_rdata;
    logic [7:0]  core_lo_v = 8'h00, core_hi_v = 8'h00;

    logic        t_job_valid = 1'b0, t_job_ready;
    logic [15:0] t_job_data = 16'h0;
    logic        t_res_valid, t_res_timeout, t_core_reset, t_core_start;
    logic [15:0] t_res_data;
    logic        t_mem_sel, t_mem_we;
    logic [7:0]  t_mem_addr, t_mem_wdata;
`ifdef CONV_SEQ_STATS_EN
    logic [15:0] job_count, t_job_count;
    logic [7:0]  timeout_count, t_timeout_count;
`endif

    conv_job_sequencer #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst),
        .job_valid(job_valid), .job_ready(job_ready), .job_data(job_data),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_timeout(res_timeout),
        .core_reset(core_reset), .core_start(core_start), .core_done(core_done),
        .mem_sel(mem_sel), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
`ifdef CONV_SEQ_STATS_EN
        , .job_count(job_count), .timeout_count(timeout_count)
`endif
    );

    conv_job_sequencer #(.TIMEOUT_CYCLES(TMO_T)) dut_t (
        .clk(clk), .rst(rst),
        .job_valid(t_job_valid), .job_ready(t_job_ready), .job_data(t_job_data),
        .res_valid(t_res_valid), .res_ready(1'b1), .res_data(t_res_data), .res_timeout(t_res_timeout),
        .core_reset(t_core_reset), .core_start(t_core_start), .core_done(1'b0),
        .mem_sel(t_mem_sel), .mem_we(t_mem_we), .mem_addr(t_mem_addr), .mem_wdata(t_mem_wdata),
        .mem_rdata(8'h00)
`ifdef CONV_SEQ_STATS_EN
        , .job_count(t_job_count), .timeout_count(t_timeout_count)
`endif
    );

    always #5 clk = ~clk;

    // Core result bytes appear at OUT_LO/OUT_HI once the core model finishes
    assign mem_rdata = (mem_addr == 8'd2) ? core_lo_v :
                       (mem_addr == 8'd3) ? core_hi_v : 8'h00;

    typedef struct packed {
        logic [15:0] data;
        logic        to;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0, n_errors = 0;
    int   cyc = 0;

    int       core_delay = 0, acc_cyc = 0, jobs_issued = 0;
    logic [7:0] core_lo = 8'h0, core_hi = 8'h0;
    bit       core_never = 1'b0, stale_req = 1'b0;
    int       cd = 0, start_cyc = 0, done_cyc = 0, n_starts = 0;
    int       wr_count = 0;
    logic [7:0] wr0 = 8'h0, wr1 = 8'h0;
    bit       prev_valid = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Core model: done pulse core_delay cycles after core_start, plus optional stale level
    always @(negedge clk) begin
        core_done = stale_req;
        if (core_start) begin
            start_cyc = cyc;
            n_starts++;
            check("start_latency", 32'(start_cyc - acc_cyc), 32'd4);
            check("start_mem_sel", {31'd0, mem_sel}, 32'd0);
            cd = core_never ? 0 : core_delay;
        end else if (cd > 0) begin
            cd--;
            if (cd == 0) begin
                core_lo_v = core_lo;
                core_hi_v = core_hi;
                core_done = 1'b1;
                done_cyc  = cyc;
            end
        end
    end

    // Memory write observer
    always @(negedge clk) begin
        if (mem_we) begin
            check("we_mem_sel", {31'd0, mem_sel}, 32'd1);
            wr_count++;
            if (mem_addr == 8'd0) wr0 = mem_wdata;
            if (mem_addr == 8'd1) wr1 = mem_wdata;
        end
    end

    // Result monitor: compares every valid cycle against the scoreboard head
    always begin
        @(negedge clk);
        #1;
        if (res_valid) begin
            if (q.size() == 0) begin
                n_errors++;
                $display("FAIL unexpected_result: got data 0x%0h with empty scoreboard (cycle %0d)", res_data, cyc);
            end else begin
                check("res_data", 32'(res_data), 32'(q[0].data));
                check("res_timeout", {31'd0, res_timeout}, {31'd0, q[0].to});
                if (!prev_valid)
                    check("res_latency", 32'(cyc),
                          q[0].to ? 32'(start_cyc + 1 + int'(TMO)) : 32'(done_cyc + 3));
                if (res_ready) void'(q.pop_front());
            end
        end
        prev_valid = res_valid;
    end

    task automatic run_job(input logic [15:0] d, input int delay, input logic [7:0] lo, input logic [7:0] hi,
                           input bit never, input bit stall, input bit expect_res);
        int   wc0, b;
        exp_t e;
        core_delay = delay;
        core_lo    = lo;
        core_hi    = hi;
        core_never = never;
        wc0        = wr_count;
        if (expect_res) begin
            e.data = never ? 16'hFFFF : {hi, lo};
            e.to   = never;
            q.push_back(e);
        end
        if (stall) res_ready = 1'b0;
        @(negedge clk);
        job_valid = 1'b1;
        job_data  = d;
        b = 0;
        while (!job_ready && b < 50) begin @(negedge clk); b++; end
        check("job_ready_idle", {31'd0, job_ready}, 32'd1);
        acc_cyc = cyc;
        jobs_issued++;
        @(negedge clk);
        job_valid = 1'b0;
        job_data  = 16'h0;
        check("job_ready_busy", {31'd0, job_ready}, 32'd0);
        if (!expect_res) return;
        if (stall) begin
            b = 0;
            while (!res_valid && b < 300) begin @(negedge clk); b++; end
            for (int i = 0; i < 5; i++) begin
                check("stall_res_valid", {31'd0, res_valid}, 32'd1);
                check("stall_job_ready", {31'd0, job_ready}, 32'd0);
                @(negedge clk);
            end
            res_ready = 1'b1;
        end
        b = 0;
        while (q.size() != 0 && b < 300) begin @(negedge clk); b++; end
        check("result_received", 32'(q.size()), 32'd0);
        check("core_starts", 32'(n_starts), 32'(jobs_issued));
        check("wr_count", 32'(wr_count - wc0), 32'd2);
        check("wr_lo", 32'(wr0), 32'(d[7:0]));
        check("wr_hi", 32'(wr1), 32'(d[15:8]));
    endtask

    initial begin
        int b, ts;
        // Reset values
        repeat (3) @(negedge clk);
        check("rst_job_ready", {31'd0, job_ready}, 32'd1);
        check("rst_res_valid", {31'd0, res_valid}, 32'd0);
        check("rst_res_timeout", {31'd0, res_timeout}, 32'd0);
        check("rst_res_data", 32'(res_data), 32'd0);
        check("rst_core_start", {31'd0, core_start}, 32'd0);
        check("rst_core_reset", {31'd0, core_reset}, 32'd1);
        check("rst_mem_we", {31'd0, mem_we}, 32'd0);
        check("rst_mem_sel", {31'd0, mem_sel}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("post_rst_job_ready", {31'd0, job_ready}, 32'd1);
        check("post_rst_core_reset", {31'd0, core_reset}, 32'd0);

        // Short-timeout instance: result 16 cycles after entering WAIT
        t_job_valid = 1'b1;
        t_job_data  = 16'h4321;
        check("t_job_ready", {31'd0, t_job_ready}, 32'd1);
        ts = cyc;
        @(negedge clk);
        t_job_valid = 1'b0;
        b = 0;
        while (!t_core_start && b < 20) begin @(negedge clk); b++; end
        check("t_start_latency", 32'(cyc - ts), 32'd4);
        ts = cyc;
        b = 0;
        while (!t_res_valid && b < 60) begin @(negedge clk); b++; end
        check("t_timeout_latency", 32'(cyc - ts), 32'd17);
        check("t_res_data", 32'(t_res_data), 32'hFFFF);
        check("t_res_timeout", {31'd0, t_res_timeout}, 32'd1);
        @(negedge clk);

        run_job(16'h0001, 20, 8'h00, 8'h1C, 1'b0, 1'b0, 1'b1);
        run_job(16'h1234, 0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1);
        run_job(16'h8000, 5, 8'h34, 8'h12, 1'b0, 1'b1, 1'b1);
        run_job(16'h00FF, 3, 8'hCD, 8'hAB, 1'b0, 1'b0, 1'b1);
`ifdef CONV_SEQ_STATS_EN
        check("job_count_4", 32'(job_count), 32'd4);
        check("timeout_count_1", 32'(timeout_count), 32'd1);
`endif

        // Abort mid-WAIT with a one-cycle reset
        run_job(16'h5555, 0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
        b = 0;
        while (n_starts != jobs_issued && b < 20) begin @(negedge clk); b++; end
        check("abort_started", 32'(n_starts), 32'(jobs_issued));
        repeat (3) @(negedge clk);
        check("abort_in_wait", {31'd0, mem_sel}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("abort_core_reset", {31'd0, core_reset}, 32'd1);
        check("abort_job_ready", {31'd0, job_ready}, 32'd1);
        check("abort_res_valid", {31'd0, res_valid}, 32'd0);
        check("abort_mem_sel", {31'd0, mem_sel}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("abort_idle_ready", {31'd0, job_ready}, 32'd1);
`ifdef CONV_SEQ_STATS_EN
        check("job_count_clr", 32'(job_count), 32'd0);
        check("timeout_count_clr", 32'(timeout_count), 32'd0);
`endif
        repeat (TMO + 10) @(negedge clk);

        run_job(16'h7F80, 2, 8'h11, 8'hEE, 1'b0, 1'b0, 1'b1);

        // Stale done level from before the job must only count in WAIT
        stale_req = 1'b1;
        repeat (2) @(negedge clk);
        run_job(16'hA5C3, 1, 8'h66, 8'h99, 1'b0, 1'b0, 1'b1);
        stale_req = 1'b0;
        repeat (3) @(negedge clk);
`ifdef CONV_SEQ_STATS_EN
        check("job_count_end", 32'(job_count), 32'd2);
        check("timeout_count_end", 32'(timeout_count), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/conv_job_sequencer.md
CONV_JOB_SEQUENCER -- requirements
Module: conv_job_sequencer

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 4096, max core cycles waited for core_done per job.
REQ-002 SHALL have parameters IN_LO_ADDR=0, IN_HI_ADDR=1, OUT_LO_ADDR=2, OUT_HI_ADDR=3, the data-memory byte addresses used for operand and result.
REQ-003 SHALL have port clk  in  1  the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst  in  1  reset, synchronous, active-low.
REQ-005 SHALL have ports job_valid in 1 / job_ready out 1 / job_data in 16, carrying the fixed 8.8 operand.
REQ-006 SHALL have ports res_valid out 1 / res_ready in 1 / res_data out 16 (float16) / res_timeout out 1.
REQ-007 SHALL have ports core_reset out 1 (active-high core reset), core_start out 1, core_done in 1.
REQ-008 SHALL have ports mem_sel out 1 (1 = sequencer owns the data-memory port, 0 = core), mem_we out 1, mem_addr out 8, mem_wdata out 8, mem_rdata in 8 (combinational read).

Function
REQ-009 SHALL implement states IDLE, CRST, WR_LO, WR_HI, START, WAIT, RD_LO, RD_HI, RESP.
REQ-010 SHALL assert job_ready only in IDLE; a job is accepted on job_valid & job_ready, and job_data is latched in the same cycle.
REQ-011 SHALL move IDLE->CRST on accept; in CRST assert core_reset for exactly 1 cycle.
REQ-012 SHALL in WR_LO drive mem_we=1, mem_addr=IN_LO_ADDR, mem_wdata=job[7:0]; in WR_HI drive the same with IN_HI_ADDR and job[15:8].
REQ-013 SHALL in START assert core_start for exactly 1 cycle, drive mem_sel=0, clear the wait counter, then enter WAIT.
REQ-014 SHALL hold mem_sel=0 in START and WAIT only, and mem_sel=1 in every other state; mem_we SHALL be 0 outside WR_LO/WR_HI.
REQ-015 SHALL sample core_done only in WAIT; a core_done level in any other state is ignored.
REQ-016 SHALL in WAIT increment the counter each cycle; core_done=1 -> RD_LO; counter == TIMEOUT_CYCLES-1 without done -> RESP with res_data=16'hFFFF and res_timeout=1.
REQ-017 SHALL give core_done priority over timeout when both occur in the same cycle.
REQ-018 SHALL in RD_LO/RD_HI drive mem_addr=OUT_LO_ADDR/OUT_HI_ADDR and capture mem_rdata into res_data[7:0]/[15:8], with res_timeout=0.
REQ-019 SHALL in RESP assert res_valid, hold res_data and res_timeout stable until res_ready, then return to IDLE in the next cycle.
REQ-020 SHALL have a latency of accept at cycle T -> core_start at T+4; done seen at cycle D -> res_valid at D+3.
REQ-021 SHALL not accept a new job before RESP completes (one job in flight).

Reset
REQ-022 SHALL, with rst=0 at a clock edge, enter IDLE, clear the counter, job latch and res_data, and drive res_valid=0, res_timeout=0, core_start=0, mem_we=0, mem_sel=1, and core_reset=1 while rst=0.
REQ-023 SHALL abort a job in any state on reset, without emitting a result.
REQ-024 SHALL have job_ready=1 in the first cycle after rst returns to 1.

Configuration
REQ-025 SHALL, with macro CONV_SEQ_STATS_EN defined, add output job_count (16 bits, counts completed results) and output timeout_count (8 bits, counts timeouts); both saturate, clear on reset, and increment on the RESP handshake.
REQ-026 SHALL, without CONV_SEQ_STATS_EN, have neither port nor its logic; all other behaviour is identical.

Verification
REQ-027 SHALL cover: job 0x0001; core model writes dm2=0x00, dm3=0x1C and raises done 20 cycles after start -> mem writes 0x01@0 and 0x00@1, res_data=0x1C00, res_timeout=0, res_valid 3 cycles after done.
REQ-028 SHALL cover: TIMEOUT_CYCLES=16, core never raises done -> res_valid with res_data=0xFFFF and res_timeout=1, 16 cycles after entering WAIT.
REQ-029 SHALL cover: job 0x8000 with res_ready held low 5 cycles -> res_data stable for all 5 cycles, job_ready=0, no second core_start.
REQ-030 SHALL cover: rst=0 for 1 cycle mid-WAIT -> IDLE next cycle, no res_valid, core_reset high during reset, a subsequent job completes normally.
REQ-031 SHALL cover: stale core_done=1 held through CRST..START -> ignored until WAIT, and RD_LO entered on the first WAIT cycle.
REQ-032 SHALL cover: with CONV_SEQ_STATS_EN, 3 normal jobs and 1 timeout -> job_count=4, timeout_count=1.
